// File: rtl/park_space_manager_if.sv
// Bundle of entry/exit request and lot status signals for the parking space manager.
// The master side drives car arrivals and departures; the slave side is the manager.
interface park_space_manager_if;
  logic       enter_req;
  logic [2:0] park_number;
  logic       exit_req;
  logic [2:0] exit_space;
  logic [7:0] parking_capacity;
  logic [3:0] free_count;
  logic       full;
  logic       empty;
  logic       enter_ack;
  logic [2:0] assigned_space;
  logic       entry_gate;
  logic       enter_deny;
  logic       exit_ack;
  logic       exit_err;

  modport master (
    output enter_req, park_number, exit_req, exit_space,
    input  parking_capacity, free_count, full, empty, enter_ack,
           assigned_space, entry_gate, enter_deny, exit_ack, exit_err
  );

  modport slave (
    input  enter_req, park_number, exit_req, exit_space,
    output parking_capacity, free_count, full, empty, enter_ack,
           assigned_space, entry_gate, enter_deny, exit_ack, exit_err
  );
endinterface

// File: rtl/park_space_manager.sv
// Eight-space parking manager: claims spaces through a gated entry FSM and
// releases them on exit pulses, keeping a free map and a matching free count.
module park_space_manager #(
  parameter int unsigned GATE_CYCLES = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  park_space_manager_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, GATE_OPEN, WAIT_CLR} state_t;

  localparam logic [3:0] GATE_LOAD = 4'(GATE_CYCLES);

  state_t     state, state_next;
  logic [3:0] gate_cnt, gate_cnt_next;
  logic [7:0] cap, cap_next;
  logic [3:0] count, count_next;
  logic [2:0] asg;
  logic       claim, deny;
  logic       rel_ok, rel_err;
  logic [7:0] claim_mask, rel_mask;
  logic       ack_q, deny_q, xack_q, xerr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gate_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      gate_cnt <= gate_cnt_next;
    end
  end

  // A held enter_req claims only from IDLE, so WAIT_CLR blocks repeat claims.
  always_comb begin
    state_next    = state;
    gate_cnt_next = gate_cnt;
    claim         = 1'b0;
    deny          = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enter_req) begin
          if (count != 4'd0) begin
            claim         = 1'b1;
            gate_cnt_next = GATE_LOAD;
            state_next    = GATE_OPEN;
          end else begin
            deny = 1'b1;
          end
        end
      end
      GATE_OPEN: begin
        gate_cnt_next = (gate_cnt != 4'd0) ? gate_cnt - 4'd1 : 4'd0;
        if (gate_cnt <= 4'd1) state_next = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!bus.enter_req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Release is judged against the pre-edge map; a claim of the same bit wins.
  always_comb begin
    rel_ok     = bus.exit_req && !cap[bus.exit_space];
    rel_err    = bus.exit_req &&  cap[bus.exit_space];
    claim_mask = claim  ? (8'd1 << bus.park_number) : 8'd0;
    rel_mask   = rel_ok ? (8'd1 << bus.exit_space)  : 8'd0;
    cap_next   = (cap | rel_mask) & ~claim_mask;
    count_next = 4'($countones(cap_next));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap    <= 8'hFF;
      count  <= 4'd8;
      asg    <= 3'd0;
      ack_q  <= 1'b0;
      deny_q <= 1'b0;
      xack_q <= 1'b0;
      xerr_q <= 1'b0;
    end else begin
      cap    <= cap_next;
      count  <= count_next;
      if (claim) asg <= bus.park_number;
      ack_q  <= claim;
      deny_q <= deny;
      xack_q <= rel_ok;
      xerr_q <= rel_err;
    end
  end

  assign bus.parking_capacity = cap;
  assign bus.free_count       = count;
  assign bus.full             = (count == 4'd0);
  assign bus.empty            = (count == 4'd8);
  assign bus.enter_ack        = ack_q;
  assign bus.assigned_space   = asg;
  assign bus.entry_gate       = (state == GATE_OPEN);
  assign bus.enter_deny       = deny_q;
  assign bus.exit_ack         = xack_q;
  assign bus.exit_err         = xerr_q;

endmodule

// File: doc/park_space_manager.md
PARK_SPACE_MANAGER -- requirements
Module: park_space_manager

Interface
REQ-001 Parameter GATE_CYCLES, default 4, SHALL set the number of cycles entry_gate stays high per admitted car (range 1..15).
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 enter_req  input  1  level; car present at entry gate.
REQ-005 park_number  input  3  index of highest-numbered free space, from the priority encoder driven by parking_capacity.
REQ-006 exit_req  input  1  single-cycle pulse; car leaving.
REQ-007 exit_space  input  3  index of the space being vacated; valid with exit_req.
REQ-008 parking_capacity  output  8  free map, bit i = 1 means space i free; registered.
REQ-009 free_count  output  4  number of free spaces, 0..8; registered.
REQ-010 full  output  1  high when free_count = 0.
REQ-011 empty  output  1  high when free_count = 8.
REQ-012 enter_ack  output  1  one-cycle pulse; space claimed.
REQ-013 assigned_space  output  3  space claimed by the last admitted car; held until the next claim.
REQ-014 entry_gate  output  1  gate-open drive.
REQ-015 enter_deny  output  1  level; entry refused because lot full.
REQ-016 exit_ack / exit_err  output  1 each  one-cycle pulses: valid release / release of an already-free space.

Function
REQ-017 Entry FSM states SHALL be IDLE, GATE_OPEN, WAIT_CLR.
REQ-018 IDLE, enter_req=1, full=0: at the edge SHALL clear parking_capacity[park_number], load assigned_space<=park_number, pulse enter_ack next cycle, load gate counter with GATE_CYCLES, go GATE_OPEN.
REQ-019 IDLE, enter_req=1, full=1: SHALL stay IDLE, enter_deny=1 the following cycle, no map change; enter_deny SHALL drop the cycle after enter_req or full falls.
REQ-020 GATE_OPEN: entry_gate=1 for exactly GATE_CYCLES cycles, counter decrements each cycle, then go WAIT_CLR.
REQ-021 WAIT_CLR: entry_gate=0; SHALL remain until enter_req=0, then IDLE; one held enter_req SHALL claim at most one space.
REQ-022 Exit: exit_req=1 and parking_capacity[exit_space]=0 SHALL set that bit and pulse exit_ack next cycle; bit already 1 SHALL pulse exit_err, map unchanged. Exit SHALL be processed in every FSM state.
REQ-023 Exit checks SHALL use the map value before the current edge; same-cycle claim and release SHALL both take effect (different bits, or release-of-claimed-space flagged exit_err and bit ends cleared).
REQ-024 Same-cycle claim and valid release SHALL leave free_count unchanged; in general free_count SHALL equal the popcount of parking_capacity every cycle, never wrapping below 0 or above 8.
REQ-025 full and empty SHALL be derived from registered free_count (no extra latency beyond the map update).
REQ-026 Only decoded one-hot writes of a 3-bit index SHALL modify the map; no other bit may change.

Reset
REQ-027 rst_n=0 at an edge SHALL force: parking_capacity=8'hFF, free_count=8, empty=1, full=0, FSM=IDLE, gate counter=0, assigned_space=0, entry_gate=0, enter_ack=0, enter_deny=0, exit_ack=0, exit_err=0.
REQ-028 Reset mid-GATE_OPEN SHALL drop entry_gate the next cycle and discard all occupancy; inputs SHALL be ignored while rst_n=0.

Verification
REQ-029 After reset, enter_req=1 with park_number=7 -> enter_ack pulse, assigned_space=7, parking_capacity=8'h7F, free_count=7, entry_gate high 4 cycles, FSM waits in WAIT_CLR until enter_req=0.
REQ-030 Eight sequential admissions (park_number 7..0) -> parking_capacity=8'h00, full=1; ninth enter_req -> enter_deny=1, no enter_ack, map unchanged.
REQ-031 Map 8'h00, exit_req with exit_space=3 -> exit_ack, parking_capacity=8'h08, free_count=1, full=0.
REQ-032 Map 8'hFF, exit_req with exit_space=5 -> exit_err, map 8'hFF, free_count=8.
REQ-033 Map 8'h0F, same cycle claim park_number=3 and exit_space=6 -> map 8'h47, free_count=4, enter_ack and exit_ack both pulse.
REQ-034 rst_n low during GATE_OPEN with map 8'h3C -> next cycle map 8'hFF, entry_gate=0, FSM IDLE.
